// File: rtl/rvc_mem_arb_pkg.sv
// rvc_mem_arb_pkg
// Shared types and constants for the memory arbiter slice.
//   MAX_MEM_PORTS : upper bound on requestor channels
//   PORT_ID_W     : width of the port-id field in an in-flight tag
//   t_mem_tag     : per-access tag carried down the response pipeline
package rvc_mem_arb_pkg;

  localparam int MAX_MEM_PORTS = 8;
  localparam int PORT_ID_W     = $clog2(MAX_MEM_PORTS);

  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
    logic                 is_write;
  } t_mem_tag;

endpackage

// File: rtl/rvc_mem_arb_rr_arb.sv
// rvc_rr_arb
// Round-robin arbiter with a registered priority pointer.
//   i_clock : core clock
//   i_rst_n : asynchronous active-low reset
//   i_req   : per-port request vector
//   o_gnt   : one-hot grant (all zero while in reset or when idle)
module rvc_rr_arb #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 i_clock,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_gnt
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [NUM_PORTS-1:0] w_gnt;

  // Walk the ports starting at the pointer; the first requester wins and
  // the pointer moves just past it. With nobody requesting the pointer holds.
  always_comb begin
    int         w_pos;
    logic [PTR_W-1:0] w_idx;
    logic       w_found;
    w_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_pos     = 0;
    w_idx     = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      w_pos = int'(r_ptr) + off;
      if (w_pos >= NUM_PORTS) begin
        w_pos = w_pos - NUM_PORTS;
      end
      w_idx = PTR_W'(w_pos);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_ptr_nxt    = (w_pos == NUM_PORTS - 1) ? '0 : PTR_W'(w_pos + 1);
      end
    end
    // Grants are suppressed while reset is held so no command leaks out.
    if (!i_rst_n) begin
      w_gnt     = '0;
      w_ptr_nxt = r_ptr;
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/rvc_mem_arb.sv
// rvc_mem_arb
// Pipelined arbiter between NUM_PORTS requestors and one fixed-latency memory.
// One request is granted per cycle, forwarded to memory combinationally, and
// its response is routed back MEM_LAT+1 cycles later.
//   i_clock / i_rst_n       : clock, asynchronous active-low reset
//   i_req_*                 : per-port request channel (valid, addr, wr, be, data)
//   o_req_gnt               : one-hot grant in the accepting cycle
//   o_rsp_valid / o_rsp_data: per-port response pulse, shared data bus
//   o_mem_*                 : memory command (zero when no grant)
//   i_mem_rd_data           : memory read data, MEM_LAT cycles after command
module rvc_mem_arb #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                                 i_clock,
  input  logic                                 i_rst_n,
  input  logic [NUM_PORTS-1:0]                 i_req_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_PORTS-1:0]                 i_req_wr_en,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   i_req_byte_en,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]     i_req_wr_data,
  output logic [NUM_PORTS-1:0]                 o_req_gnt,
  output logic [NUM_PORTS-1:0]                 o_rsp_valid,
  output logic [DATA_W-1:0]                    o_rsp_data,
  output logic                                 o_mem_req,
  output logic [ADDR_W-1:0]                    o_mem_addr,
  output logic                                 o_mem_wr_en,
  output logic [DATA_W/8-1:0]                  o_mem_byte_en,
  output logic [DATA_W-1:0]                    o_mem_wr_data,
  input  logic [DATA_W-1:0]                    i_mem_rd_data
);

  import rvc_mem_arb_pkg::*;

  localparam int BE_W = DATA_W / 8;

  logic [NUM_PORTS-1:0] w_gnt;
  t_mem_tag             w_tag_in;
  t_mem_tag             r_tag [MEM_LAT+1];
  logic [DATA_W-1:0]    r_rsp_data;
  logic [NUM_PORTS-1:0] w_rsp_valid;

  rvc_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arb (
    .i_clock (i_clock),
    .i_rst_n (i_rst_n),
    .i_req   (i_req_valid),
    .o_gnt   (w_gnt)
  );

  assign o_req_gnt = w_gnt;
  assign o_mem_req = |w_gnt;

  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_byte_en = '0;
    o_mem_wr_data = '0;
    w_tag_in      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_gnt[i]) begin
        o_mem_addr        = i_req_addr[i];
        o_mem_wr_en       = i_req_wr_en[i];
        o_mem_byte_en     = i_req_byte_en[i];
        o_mem_wr_data     = i_req_wr_data[i];
        w_tag_in.valid    = 1'b1;
        w_tag_in.port_id  = PORT_ID_W'(i);
        w_tag_in.is_write = i_req_wr_en[i];
      end
    end
  end

  // Tag stage k holds the access granted k+1 cycles ago. Read data is
  // captured on the same edge that moves a tag into the final stage, so
  // data and tag leave together.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= MEM_LAT; i++) begin
        r_tag[i] <= '0;
      end
      r_rsp_data <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= MEM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      if (r_tag[MEM_LAT-1].valid && !r_tag[MEM_LAT-1].is_write) begin
        r_rsp_data <= i_mem_rd_data;
      end else begin
        r_rsp_data <= '0;
      end
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_tag[MEM_LAT].valid && (r_tag[MEM_LAT].port_id == PORT_ID_W'(i))) begin
        w_rsp_valid[i] = 1'b1;
      end
    end
  end

  assign o_rsp_valid = w_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rvc_mem_arb.sv
// tb_rvc_mem_arb
// Randomised bench for rvc_mem_arb with a behavioural memory, a reference
// round-robin model and a response scoreboard.
module tb_rvc_mem_arb;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ML  = 3;
  localparam int BEW = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NP-1:0]           req_valid;
  logic [NP-1:0][AW-1:0]   req_addr;
  logic [NP-1:0]           req_wr_en;
  logic [NP-1:0][BEW-1:0]  req_be;
  logic [NP-1:0][DW-1:0]   req_wd;
  logic [NP-1:0]           o_req_gnt;
  logic [NP-1:0]           o_rsp_valid;
  logic [DW-1:0]           o_rsp_data;
  logic                    o_mem_req;
  logic [AW-1:0]           o_mem_addr;
  logic                    o_mem_wr_en;
  logic [BEW-1:0]          o_mem_byte_en;
  logic [DW-1:0]           o_mem_wr_data;
  logic [DW-1:0]           mem_rd_data;

  rvc_mem_arb #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_LAT   (ML)
  ) dut (
    .i_clock       (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .i_req_addr    (req_addr),
    .i_req_wr_en   (req_wr_en),
    .i_req_byte_en (req_be),
    .i_req_wr_data (req_wd),
    .o_req_gnt     (o_req_gnt),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_data    (o_rsp_data),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_byte_en (o_mem_byte_en),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [int];
  logic [DW-1:0] slot [8];
  int            ptr_m = 0;
  logic [NP-1:0] g_last = '0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    int k;
    k = int'(a >> 2);
    if (mem.exists(k)) return mem[k];
    return '0;
  endfunction

  // Reference arbitration: lowest requesting port at or above the pointer,
  // otherwise the lowest requesting port overall.
  function automatic int pick(input logic [NP-1:0] req, input int ptr);
    int lo;
    int hi;
    lo = -1;
    hi = -1;
    for (int p = 0; p < NP; p++) begin
      if (req[p]) begin
        if (p >= ptr && hi < 0) hi = p;
        if (lo < 0) lo = p;
      end
    end
    return (hi >= 0) ? hi : lo;
  endfunction

  // Memory environment, grant/command checker, expectation producer.
  int            a_p;
  int            a_k;
  logic [NP-1:0] a_eg;
  logic [DW-1:0] a_w;
  exp_t          a_e;

  always @(negedge clk) begin
    mem_rd_data    = slot[cyc % 8];
    slot[cyc % 8]  = $urandom;
    if (!rst_n) begin
      chk("gnt_in_reset", 64'(o_req_gnt), 64'(0));
      chk("mem_req_in_reset", 64'(o_mem_req), 64'(0));
      exp_q.delete();
      ptr_m  = 0;
      g_last = '0;
    end else begin
      a_p  = pick(req_valid, ptr_m);
      a_eg = '0;
      if (a_p >= 0) a_eg[a_p] = 1'b1;
      chk("gnt", 64'(o_req_gnt), 64'(a_eg));
      chk("mem_req", 64'(o_mem_req), 64'(a_p >= 0));
      if (a_p >= 0) begin
        chk("mem_addr", 64'(o_mem_addr), 64'(req_addr[a_p]));
        chk("mem_wr_en", 64'(o_mem_wr_en), 64'(req_wr_en[a_p]));
        if (req_wr_en[a_p]) begin
          chk("mem_byte_en", 64'(o_mem_byte_en), 64'(req_be[a_p]));
          chk("mem_wr_data", 64'(o_mem_wr_data), 64'(req_wd[a_p]));
          a_e.data = '0;
        end else begin
          a_e.data = mem_rd(req_addr[a_p]);
        end
        a_e.port = a_p;
        a_e.due  = cyc + ML + 1;
        exp_q.push_back(a_e);
        ptr_m = (a_p + 1) % NP;
      end else begin
        chk("mem_idle_fields", {o_mem_addr, o_mem_wr_data}, 64'(0));
      end
      if (o_mem_req) begin
        if (o_mem_wr_en) begin
          a_k = int'(o_mem_addr >> 2);
          a_w = mem_rd(o_mem_addr);
          for (int b = 0; b < BEW; b++) begin
            if (o_mem_byte_en[b]) a_w[8*b +: 8] = o_mem_wr_data[8*b +: 8];
          end
          mem[a_k] = a_w;
        end else begin
          slot[(cyc + ML) % 8] = mem_rd(o_mem_addr);
        end
      end
      g_last = o_req_gnt;
    end
  end

  // Response monitor.
  exp_t          m_e;
  logic [NP-1:0] m_oh;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rsp_valid_in_reset", 64'(o_rsp_valid), 64'(0));
      chk("rsp_data_in_reset", 64'(o_rsp_data), 64'(0));
    end else if (o_rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(o_rsp_valid), 64'(0));
      end else begin
        m_e  = exp_q.pop_front();
        m_oh = '0;
        m_oh[m_e.port] = 1'b1;
        chk("rsp_port", 64'(o_rsp_valid), 64'(m_oh));
        chk("rsp_data", 64'(o_rsp_data), 64'(m_e.data));
        chk("rsp_cycle", 64'(cyc), 64'(m_e.due));
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      m_e  = exp_q.pop_front();
      m_oh = '0;
      m_oh[m_e.port] = 1'b1;
      chk("rsp_missing", 64'(o_rsp_valid), 64'(m_oh));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] addr,
                         input logic [BEW-1:0] be, input logic [DW-1:0] wd);
    req_valid[p] = 1'b1;
    req_wr_en[p] = wr;
    req_addr[p]  = addr;
    req_be[p]    = be;
    req_wd[p]    = wd;
  endtask

  task automatic new_req(input int p, input bit allow_wr);
    set_req(p, allow_wr && ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15) * 4),
            BEW'($urandom), DW'($urandom));
  endtask

  initial begin
    req_valid   = '0;
    req_addr    = '0;
    req_wr_en   = '0;
    req_be      = '0;
    req_wd      = '0;
    mem_rd_data = '0;
    for (int i = 0; i < 8; i++) slot[i] = '0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;

    // Everyone requests while reset is held: nothing may be granted.
    for (int p = 0; p < NP; p++) new_req(p, 1'b1);
    repeat (3) tick();
    rst_n     = 1'b1;
    req_valid = '0;
    repeat (2) tick();

    // Single read from port 1.
    set_req(1, 1'b0, 32'h100, '0, '0);
    tick();
    req_valid[1] = 1'b0;
    repeat (6) tick();

    // All ports contend continuously; each re-requests once served.
    for (int p = 0; p < NP; p++) new_req(p, 1'b0);
    repeat (10) begin
      tick();
      for (int p = 0; p < NP; p++) if (g_last[p]) new_req(p, 1'b0);
    end
    req_valid = '0;
    repeat (6) tick();

    // Write ack, then read back the partially written word.
    set_req(0, 1'b1, 32'h40, 4'b0011, 32'h12345678);
    tick();
    req_valid[0] = 1'b0;
    repeat (6) tick();
    set_req(3, 1'b0, 32'h40, '0, '0);
    tick();
    req_valid[3] = 1'b0;
    repeat (6) tick();

    // Reset while two reads are in flight.
    set_req(0, 1'b0, 32'h100, '0, '0);
    set_req(1, 1'b0, 32'h40, '0, '0);
    tick();
    for (int p = 0; p < NP; p++) if (g_last[p]) req_valid[p] = 1'b0;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    set_req(2, 1'b0, 32'h100, '0, '0);
    set_req(0, 1'b0, 32'h40, '0, '0);
    tick();
    for (int p = 0; p < NP; p++) if (g_last[p]) req_valid[p] = 1'b0;
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Randomised traffic with holds, drops and idle gaps.
    repeat (400) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p]) begin
          if (g_last[p]) begin
            req_valid[p] = 1'b0;
            if ($urandom_range(0, 1) == 1) new_req(p, 1'b1);
          end else if ($urandom_range(0, 19) == 0) begin
            req_valid[p] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(p, 1'b1);
        end
      end
    end
    req_valid = '0;
    repeat (ML + 4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvc_mem_arb.md
# rvc_mem_arb

Parametrised, pipelined memory arbiter between the rvc_asap core's memory ports (and any further requestors) and a single-ported shared memory with fixed read latency. Replaces the fixed one-instruction-port, one-data-port hookup with NUM_PORTS request/response channels. Each cycle it grants at most one request round-robin and forwards it to memory. It tags each in-flight access with its port ID and routes the registered response back to the originating port.

## Interface
Parameters:
- NUM_PORTS, 2, number of requestor channels (2..8); port 0 = I_MEM fetch, port 1 = D_MEM.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MEM_LAT, 1, memory read latency in cycles (1..4).

Ports:
- Clock  in  1  core clock; all state on rising edge.
- Rst  in  1  asynchronous, active-low reset (low = reset).
- ReqValid  in  NUM_PORTS  per-port request.
- ReqAddr  in  NUM_PORTS x ADDR_W  per-port address.
- ReqWrEn  in  NUM_PORTS  1 = write, 0 = read.
- ReqByteEn  in  NUM_PORTS x DATA_W/8  write byte enables.
- ReqWrData  in  NUM_PORTS x DATA_W  write data.
- ReqGnt  out  NUM_PORTS  one-hot grant, same cycle as the accepted request.
- RspValid  out  NUM_PORTS  one-cycle response pulse.
- RspData  out  DATA_W  read data; shared bus, qualified by RspValid.
- MemReq  out  1  memory command valid.
- MemAddr  out  ADDR_W; MemWrEn  out  1; MemByteEn  out  DATA_W/8; MemWrData  out  DATA_W  memory command fields.
- MemRdData  in  DATA_W  memory read data, valid MEM_LAT cycles after MemReq.

## Operation
- Arbitration:
  - Combinational round-robin over ReqValid, starting at priority pointer Ptr.
  - Grant the first requesting port at or after Ptr.
  - On a grant to port i, Ptr <= (i+1) mod NUM_PORTS. With no grant, Ptr holds.
- Command: the granted port's fields drive Mem* combinationally. MemReq = |ReqGnt. With no grant, Mem* fields drive 0.
- Requestor rule: a port holds ReqValid and all fields stable until it sees ReqGnt. Deasserting before grant is permitted; the request is simply dropped.
- Tag pipeline:
  - MEM_LAT+1 stages of {Valid, PortId, IsWrite}.
  - Stage 0 is loaded from the grant. All stages shift every cycle; there are no stalls.
- Response:
  - When the final stage is valid, RspValid[PortId] pulses.
  - Reads: RspData = MemRdData registered at stage MEM_LAT.
  - Writes: the ack pulse is still given, with RspData = 0.
- Throughput: one access per cycle sustained. Any mix of reads and writes may be in flight.
- Boundary conditions:
  - All ports idle: no grant, and Ptr holds.
  - Single requestor: granted every cycle regardless of Ptr.
  - Pointer wrap: after a grant to port NUM_PORTS-1, Ptr = 0.
  - Back-to-back requests from one port are each tagged independently and return in order.
- Reset:
  - While Rst is low: Ptr = 0, all tag stages invalid, RspValid = 0, RspData = 0.
  - ReqGnt and MemReq are forced to 0 while Rst is low.
  - In-flight accesses are discarded; their MemRdData is ignored after reset releases.

## Timing
- Grant at cycle T (combinational) -> memory command in cycle T -> MemRdData valid in cycle T+MEM_LAT -> RspValid/RspData registered, visible in cycle T+MEM_LAT+1.
- Response latency = MEM_LAT+1 cycles from grant, fixed for both reads and writes.
- Ptr update takes effect at the edge ending cycle T; the new priority applies in cycle T+1.
- Reset values: Ptr 0; RspValid all 0; RspData 0; ReqGnt 0; MemReq 0.

## Structure
- rvc_asap_pkg additions:
  - typedef t_mem_tag {logic Valid; logic [$clog2(NUM_PORTS)-1:0] PortId; logic IsWrite;}.
  - Constant MAX_MEM_PORTS = 8.
- Sub-module rvc_rr_arb:
  - Parametrised by NUM_PORTS.
  - Inputs: Clock, Rst, Req vector. Outputs: one-hot Gnt.
  - Owns Ptr.
- rvc_mem_arb instantiates rvc_rr_arb and contains the command mux, tag pipeline and response demux.

## Test plan
- Reset, then a single read: with MEM_LAT=1, port 1 reads addr 0x100 in cycle 3 and memory returns 0xDEADBEEF. Required: ReqGnt=2'b10 in cycle 3; RspValid[1] and RspData=0xDEADBEEF in cycle 5.
- Contention: both ports request continuously for 6 cycles. Required: grants alternate 01,10,01,10…; each response arrives 2 cycles after its grant on the correct port.
- Wrap/depth: NUM_PORTS=4, MEM_LAT=3, all ports request. Required: grant order 0,1,2,3,0; responses in the same order, 4 cycles after each grant.
- Write ack: port 0 writes 0x12345678 with ByteEn=4'b0011 to 0x40. Required: MemWrEn=1 and MemByteEn=0011 in the grant cycle; RspValid[0] pulses with RspData=0 at grant+MEM_LAT+1.
- Reset mid-flight: assert Rst low one cycle after two reads are granted. Required: no RspValid pulses, Ptr=0; after release, port 0 wins first.
